// File: rtl/key_entry_decoder.sv
// Operator input front end for the egg timer: debounces KEY, turns presses into events,
// and walks the seconds/minutes set-up sequence that feeds the countdown core.
module key_entry_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] KEY,
   input  logic [7:0] SW,
   output logic [3:0] SEC_TENS,
   output logic [3:0] SEC_ONES,
   output logic [3:0] MIN_TENS,
   output logic [3:0] MIN_ONES,
   output logic [1:0] SET_STATE,
   output logic       LOAD,
   output logic       START,
   output logic       CLAMPED
);

   localparam logic [CNT_W-1:0] DebLimit = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      StSetSec = 2'b00,
      StSetMin = 2'b01,
      StArmed  = 2'b10
   } state_e;

   state_e           state_q;
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       deb_q;
   logic [1:0]       press_q;
   logic [CNT_W-1:0] cnt_q [2];

   logic [3:0] sec_tens_c, ones_c, min_tens_c;
   logic       sec_tens_clip, ones_clip, min_tens_clip;

   // Synchroniser, debounce counters and press-event generation for both keys.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         deb_q   <= 2'b11;
         press_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= KEY;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] + 1'b1 == DebLimit) begin
               deb_q[i]   <= sync2_q[i];
               cnt_q[i]   <= '0;
               // A flip only happens when levels differ, so old level 1 means a 1->0 press.
               press_q[i] <= deb_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      sec_tens_c    = SW[7:4];
      sec_tens_clip = 1'b0;
      if (SW[7:4] > 4'd5) begin
         sec_tens_c    = 4'd5;
         sec_tens_clip = 1'b1;
      end
      min_tens_c    = SW[7:4];
      min_tens_clip = 1'b0;
      if (SW[7:4] > 4'd9) begin
         min_tens_c    = 4'd9;
         min_tens_clip = 1'b1;
      end
      ones_c    = SW[3:0];
      ones_clip = 1'b0;
      if (SW[3:0] > 4'd9) begin
         ones_c    = 4'd9;
         ones_clip = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StSetSec;
         SEC_TENS <= 4'd0;
         SEC_ONES <= 4'd0;
         MIN_TENS <= 4'd0;
         MIN_ONES <= 4'd0;
         LOAD     <= 1'b0;
         START    <= 1'b0;
         CLAMPED  <= 1'b0;
      end else begin
         LOAD  <= 1'b0;
         START <= 1'b0;
         unique case (state_q)
            StSetSec: begin
               if (press_q[0]) begin
                  SEC_TENS <= sec_tens_c;
                  SEC_ONES <= ones_c;
                  CLAMPED  <= CLAMPED | sec_tens_clip | ones_clip;
                  state_q  <= StSetMin;
               end
            end
            StSetMin: begin
               if (press_q[0]) begin
                  MIN_TENS <= min_tens_c;
                  MIN_ONES <= ones_c;
                  CLAMPED  <= CLAMPED | min_tens_clip | ones_clip;
                  LOAD     <= 1'b1;
                  state_q  <= StArmed;
               end
            end
            StArmed: begin
               // SET wins over a coincident START/STOP press.
               if (press_q[0]) begin
                  CLAMPED <= 1'b0;
                  state_q <= StSetSec;
               end else if (press_q[1]) begin
                  START <= 1'b1;
               end
            end
            default: state_q <= StSetSec;
         endcase
      end
   end

   assign SET_STATE = state_q;

endmodule

// File: tb/tb_key_entry_decoder.sv
// Scoreboard bench for key_entry_decoder: stimulus queues expected output events with their
// cycle of arrival, a negedge monitor pops and compares every observed output change.
module tb_key_entry_decoder;

   localparam int unsigned DEB = 4;
   // Drive cycle to observed registered-output cycle: 2 sync + DEB debounce + event + FSM.
   localparam int unsigned LAT = DEB + 3;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] KEY;
   logic [7:0] SW;
   logic [3:0] SEC_TENS, SEC_ONES, MIN_TENS, MIN_ONES;
   logic [1:0] SET_STATE;
   logic       LOAD, START, CLAMPED;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  st;
      logic        load;
      logic        start;
      logic        clamped;
      logic [15:0] dig;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs, mon_exp;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic [18:0] prev;

   key_entry_decoder #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(8)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .KEY(KEY),
      .SW(SW),
      .SEC_TENS(SEC_TENS),
      .SEC_ONES(SEC_ONES),
      .MIN_TENS(MIN_TENS),
      .MIN_ONES(MIN_ONES),
      .SET_STATE(SET_STATE),
      .LOAD(LOAD),
      .START(START),
      .CLAMPED(CLAMPED)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic ev_t mk(input logic [1:0] st, input logic ld, input logic stt,
                              input logic cl, input logic [15:0] dig);
      ev_t e;
      e.cyc     = 32'd0;
      e.st      = st;
      e.load    = ld;
      e.start   = stt;
      e.clamped = cl;
      e.dig     = dig;
      return e;
   endfunction

   always @(negedge CLK) begin
      if (mon_en) begin
         obs.cyc     = cyc;
         obs.st      = SET_STATE;
         obs.load    = LOAD;
         obs.start   = START;
         obs.clamped = CLAMPED;
         obs.dig     = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
         if ({obs.st, obs.clamped, obs.dig} !== prev || LOAD !== 1'b0 || START !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL event: unexpected output change got=%h required=none", obs);
            end else begin
               mon_exp = exp_q.pop_front();
               if (obs !== mon_exp) begin
                  errors++;
                  $display("FAIL event: got=%h required=%h (cyc,st,load,start,clamped,dig)",
                           obs, mon_exp);
               end
            end
         end
         prev = {obs.st, obs.clamped, obs.dig};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got=%h required=%h", name, act, req);
      end
   endtask

   // Hold the keys in mask low for n cycles; optionally expect one output event.
   task automatic press(input logic [1:0] mask, input int n, input logic want, input ev_t e);
      ev_t x;
      @(posedge CLK);
      #1;
      KEY   = ~mask;
      x     = e;
      x.cyc = cyc + LAT;
      if (want) exp_q.push_back(x);
      repeat (n) @(posedge CLK);
      #1;
      KEY = 2'b11;
      repeat (12) @(posedge CLK);
      #1;
   endtask

   task automatic glitch(input int n);
      @(posedge CLK);
      #1;
      KEY = 2'b10;
      repeat (n) @(posedge CLK);
      #1;
      KEY = 2'b11;
      repeat (10) @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ev_t bx;
      RESET = 1'b1;
      KEY   = 2'b11;
      SW    = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      RESET  = 1'b0;
      prev   = 19'd0;
      mon_en = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      check("reset_state", 32'(SET_STATE), 32'd0);
      check("reset_digits", 32'({MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES}), 32'd0);
      check("reset_flags", 32'({LOAD, START, CLAMPED}), 32'd0);

      // Normal entry 59 s then 10 min.
      SW = 8'h59;
      press(2'b01, 10, 1'b1, mk(2'b01, 1'b0, 1'b0, 1'b0, 16'h0059));
      check("set_min_state", 32'(SET_STATE), 32'd1);
      SW = 8'h10;
      press(2'b01, 10, 1'b1, mk(2'b10, 1'b1, 1'b0, 1'b0, 16'h1059));
      check("armed_state", 32'(SET_STATE), 32'd2);
      check("entry_queue_empty", 32'(exp_q.size()), 32'd0);

      // Two START requests, leave ARMED, then START ignored in SET_SEC.
      press(2'b10, 10, 1'b1, mk(2'b10, 1'b0, 1'b1, 1'b0, 16'h1059));
      press(2'b10, 10, 1'b1, mk(2'b10, 1'b0, 1'b1, 1'b0, 16'h1059));
      press(2'b01, 10, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h1059));
      press(2'b10, 10, 1'b0, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h1059));
      check("start_ignored_state", 32'(SET_STATE), 32'd0);
      check("start_queue_empty", 32'(exp_q.size()), 32'd0);

      // Clamping and CLAMPED lifetime.
      SW = 8'h7C;
      press(2'b01, 10, 1'b1, mk(2'b01, 1'b0, 1'b0, 1'b1, 16'h1059));
      SW = 8'hF3;
      press(2'b01, 10, 1'b1, mk(2'b10, 1'b1, 1'b0, 1'b1, 16'h9359));
      check("clamped_sticky", 32'(CLAMPED), 32'd1);
      press(2'b01, 10, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h9359));
      check("clamped_cleared", 32'(CLAMPED), 32'd0);

      // Short glitches must be filtered.
      SW = 8'h42;
      glitch(1);
      glitch(2);
      glitch(3);
      check("glitch_state", 32'(SET_STATE), 32'd0);
      check("glitch_queue_empty", 32'(exp_q.size()), 32'd0);

      // Bounce every cycle, then steady low: exactly one event from the steady part.
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK);
         #1;
         KEY = (i % 2 == 0) ? 2'b10 : 2'b11;
      end
      @(posedge CLK);
      #1;
      KEY    = 2'b10;
      bx     = mk(2'b01, 1'b0, 1'b0, 1'b0, 16'h9342);
      bx.cyc = cyc + LAT;
      exp_q.push_back(bx);
      repeat (10) @(posedge CLK);
      #1;
      KEY = 2'b11;
      repeat (12) @(posedge CLK);
      #1;
      check("bounce_state", 32'(SET_STATE), 32'd1);

      // Both keys together in ARMED: SET wins, no START.
      SW = 8'h07;
      press(2'b01, 10, 1'b1, mk(2'b10, 1'b1, 1'b0, 1'b0, 16'h0742));
      press(2'b11, 10, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0742));
      check("both_keys_state", 32'(SET_STATE), 32'd0);

      // Reset in the middle of a press while in SET_MIN.
      SW = 8'h31;
      press(2'b01, 10, 1'b1, mk(2'b01, 1'b0, 1'b0, 1'b0, 16'h0731));
      @(posedge CLK);
      #1;
      KEY = 2'b10;
      repeat (2) @(posedge CLK);
      #1;
      RESET  = 1'b1;
      KEY    = 2'b11;
      bx     = mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
      bx.cyc = cyc + 1;
      exp_q.push_back(bx);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (15) @(posedge CLK);
      #1;
      check("reset_mid_state", 32'(SET_STATE), 32'd0);
      check("reset_mid_digits", 32'({MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES}), 32'd0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
